// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, bus encodings and controller state type
package cache_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int INDEX_W = 10;
  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int WAIT_STATES_DEF = 2;
  localparam logic READ = 1'b1;
  localparam logic WRITE = 1'b0;
  typedef enum logic [2:0] {IDLE, LOOKUP, HIT_RESP, MEM_REQ, MEM_WAIT, FILL, WR_DONE} state_t;
endpackage

// File: rtl/cache_tag_store.sv
// cache_tag_store: valid+tag flop array, combinational read, one-cycle valid clear on reset
module cache_tag_store import cache_pkg::*; #(
  parameter int INDEX_WIDTH = INDEX_W,
  parameter int TAG_WIDTH = TAG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [INDEX_WIDTH-1:0] wr_idx,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic [INDEX_WIDTH-1:0] rd_idx,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag
);
  localparam int N = 1 << INDEX_WIDTH;
  logic [N-1:0] valid_q, valid_d;
  logic [N-1:0][TAG_WIDTH-1:0] tag_q, tag_d;
  always_comb begin
    valid_d = valid_q;
    tag_d = tag_q;
    if (we) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx] = wr_tag;
    end
  end
  always_ff @(posedge clk) begin
    valid_q <= rst ? '0 : valid_d;
    tag_q <= tag_d;
  end
  assign rd_valid = valid_q[rd_idx];
  assign rd_tag = tag_q[rd_idx];
endmodule

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped write-through cache FSM driving an external data RAM
module cache_controller import cache_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int INDEX_WIDTH = INDEX_W,
  parameter int WAIT_STATES = WAIT_STATES_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   PStrobe,
  input  logic                   PRW,
  input  logic [ADDR_WIDTH-1:0]  PAddress,
  input  logic [DATA_WIDTH-1:0]  PDataIn,
  output logic [DATA_WIDTH-1:0]  PDataOut,
  output logic                   PReady,
  output logic                   SysStrobe,
  output logic                   SysRW,
  output logic [ADDR_WIDTH-1:0]  SysAddress,
  output logic [DATA_WIDTH-1:0]  SysDataOut,
  input  logic [DATA_WIDTH-1:0]  SysDataIn,
  output logic [INDEX_WIDTH-1:0] DramAddr,
  output logic [DATA_WIDTH-1:0]  DramDataIn,
  output logic                   DramWrite,
  input  logic [DATA_WIDTH-1:0]  DramDataOut
);
  localparam int TW = ADDR_WIDTH - INDEX_WIDTH;
  localparam int CW = $clog2(WAIT_STATES + 1);
  state_t state_q, state_d;
  logic rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [INDEX_WIDTH-1:0] idx;
  logic [TW-1:0] tag, rd_tag;
  logic rd_valid, hit, wr_hit, fill;
  assign idx = addr_q[INDEX_WIDTH-1:0];
  assign tag = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
  assign hit = rd_valid && rd_tag == tag;
  assign wr_hit = state_q == LOOKUP && rw_q == WRITE && hit;
  assign fill = state_q == FILL;
  cache_tag_store #(.INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TW)) u_tags (
    .clk(Clk), .rst(Reset), .we(fill), .wr_idx(idx), .wr_tag(tag),
    .rd_idx(idx), .rd_valid(rd_valid), .rd_tag(rd_tag)
  );
  always_comb begin
    state_d = state_q;
    rw_d = rw_q;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (PStrobe) begin
        rw_d = PRW;
        addr_d = PAddress;
        data_d = PDataIn;
        state_d = LOOKUP;
      end
      LOOKUP: state_d = (rw_q == READ && hit) ? HIT_RESP : MEM_REQ;
      MEM_REQ: begin
        cnt_d = CW'(WAIT_STATES - 1);
        state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        state_d = cnt_q != '0 ? MEM_WAIT : rw_q == READ ? FILL : WR_DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      rw_q <= READ;
      addr_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end
  // every output is decoded from state and the captured request only
  assign PReady = state_q inside {HIT_RESP, FILL, WR_DONE};
  assign PDataOut = state_q == HIT_RESP ? DramDataOut : fill ? SysDataIn : '0;
  assign SysStrobe = state_q == MEM_REQ;
  assign SysRW = SysStrobe ? rw_q : READ;
  assign SysAddress = SysStrobe ? addr_q : '0;
  assign SysDataOut = SysStrobe ? data_q : '0;
  assign DramWrite = wr_hit || fill;
  assign DramAddr = (state_q == LOOKUP || fill) ? idx : '0;
  assign DramDataIn = wr_hit ? data_q : fill ? SysDataIn : '0;
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: transaction-level cache model predicting per-cycle outputs, plus literal checks
module tb_cache_controller;
  localparam int W = 2;
  logic Clk = 0, Reset = 1, PStrobe = 0, PRW = 1, PReady, SysStrobe, SysRW, DramWrite;
  logic [15:0] PAddress = 0, SysAddress;
  logic [31:0] PDataIn = 0, PDataOut, SysDataOut, SysDataIn = 0, DramDataIn, DramDataOut = 0;
  logic [9:0] DramAddr;
  cache_controller #(.WAIT_STATES(W)) dut (
    .Clk(Clk), .Reset(Reset), .PStrobe(PStrobe), .PRW(PRW), .PAddress(PAddress),
    .PDataIn(PDataIn), .PDataOut(PDataOut), .PReady(PReady), .SysStrobe(SysStrobe),
    .SysRW(SysRW), .SysAddress(SysAddress), .SysDataOut(SysDataOut), .SysDataIn(SysDataIn),
    .DramAddr(DramAddr), .DramDataIn(DramDataIn), .DramWrite(DramWrite), .DramDataOut(DramDataOut)
  );
  always #5 Clk = ~Clk;
  typedef struct packed {
    bit ctl, all, rdy, sstb, srw, dwr;
    logic [15:0] saddr;
    logic [31:0] pdo, sdo, ddi;
    logic [9:0] daddr;
  } exp_t;
  exp_t expq[$];
  exp_t ce;
  int ncmp = 0, nbad = 0, cur = 0, rdy_cyc = -1, cd = 0;
  logic [31:0] rdy_q, pend;
  logic [31:0] ram [1024];
  logic [31:0] mem [logic [15:0]];
  logic [31:0] mmem [logic [15:0]];
  bit mvalid [1024];
  logic [5:0] mtag [1024];
  logic [31:0] cdata [1024];
  function automatic logic [31:0] mdef(input logic [15:0] a);
    return {16'hA5A5, a};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    end
  endtask
  // environment: data RAM and fixed-latency main memory
  always @(negedge Clk) if (DramWrite) ram[DramAddr] = DramDataIn;
  always @(posedge Clk) DramDataOut <= ram[DramAddr];
  always @(negedge Clk) begin
    if (Reset) cd = 0;
    else if (SysStrobe) begin
      if (SysRW) begin
        pend = mem.exists(SysAddress) ? mem[SysAddress] : mdef(SysAddress);
        cd = W;
        SysDataIn = 32'hBAADF00D;
      end else mem[SysAddress] = SysDataOut;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) SysDataIn = pend;
    end
  end
  always @(negedge Clk) if (expq.size() > 0) begin
    ce = expq.pop_front();
    if (ce.ctl || ce.all) begin
      chk("PReady", 32'(PReady), 32'(ce.rdy));
      chk("SysStrobe", 32'(SysStrobe), 32'(ce.sstb));
      chk("DramWrite", 32'(DramWrite), 32'(ce.dwr));
      if (ce.rdy || ce.all) chk("PDataOut", PDataOut, ce.pdo);
      if (ce.sstb || ce.all) begin
        chk("SysRW", 32'(SysRW), 32'(ce.srw));
        chk("SysAddress", 32'(SysAddress), 32'(ce.saddr));
        chk("SysDataOut", SysDataOut, ce.sdo);
      end
      if (ce.dwr || ce.all) begin
        chk("DramAddr", 32'(DramAddr), 32'(ce.daddr));
        chk("DramDataIn", DramDataIn, ce.ddi);
      end
    end
    if (PReady === 1'b1) begin
      rdy_cyc = cur;
      rdy_q = PDataOut;
    end
  end
  function automatic exp_t idle_v();
    exp_t e = '0;
    e.ctl = 1;
    e.srw = 1;
    return e;
  endfunction
  task automatic cyc(input exp_t e);
    expq.push_back(e);
    @(posedge Clk);
    #1 cur++;
  endtask
  task automatic clear_model();
    for (int i = 0; i < 1024; i++) mvalid[i] = 0;
  endtask
  task automatic req(input logic rw, input logic [15:0] a, input logic [31:0] d, output int lat, output logic [31:0] q);
    exp_t e;
    logic [9:0] ix = a[9:0];
    logic [31:0] md;
    bit hit = mvalid[ix] && mtag[ix] == a[15:10];
    cur = 0;
    rdy_cyc = -1;
    PStrobe = 1; PRW = rw; PAddress = a; PDataIn = d;
    cyc(idle_v());
    PStrobe = 0; PAddress = ~a; PDataIn = ~d; PRW = ~rw;
    e = idle_v();
    if (!rw && hit) begin
      e.dwr = 1; e.daddr = ix; e.ddi = d;
      cdata[ix] = d;
    end
    cyc(e);
    if (rw && hit) begin
      e = idle_v(); e.rdy = 1; e.pdo = cdata[ix];
      cyc(e);
    end else begin
      e = idle_v(); e.sstb = 1; e.srw = rw; e.saddr = a; e.sdo = d;
      cyc(e);
      for (int i = 0; i < W; i++) cyc(idle_v());
      e = idle_v(); e.rdy = 1;
      if (rw) begin
        md = mmem.exists(a) ? mmem[a] : mdef(a);
        e.pdo = md; e.dwr = 1; e.daddr = ix; e.ddi = md;
        mvalid[ix] = 1; mtag[ix] = a[15:10]; cdata[ix] = md;
      end else mmem[a] = d;
      cyc(e);
    end
    lat = rdy_cyc;
    q = rdy_q;
  endtask
  logic [15:0] aset [8] = '{16'h0400, 16'h0000, 16'h0800, 16'h0401, 16'h1401, 16'h0123, 16'hFFFF, 16'hFBFF};
  initial begin
    exp_t e;
    int lat;
    logic [31:0] q;
    for (int i = 0; i < 1024; i++) ram[i] = 0;
    clear_model();
    mem[16'h0400] = 32'hDEADBEEF;
    mmem[16'h0400] = 32'hDEADBEEF;
    @(posedge Clk);
    #1;
    e = '0;
    cyc(e);
    cyc(e);
    Reset = 0;
    e = idle_v(); e.all = 1;
    cyc(e);
    req(1, 16'h0400, 32'h0, lat, q);
    chk("miss_lat", 32'(lat), 5); chk("miss_data", q, 32'hDEADBEEF);
    req(1, 16'h0400, 32'h0, lat, q);
    chk("hit_lat", 32'(lat), 2); chk("hit_data", q, 32'hDEADBEEF);
    req(0, 16'h0400, 32'h12345678, lat, q);
    chk("wr_hit_lat", 32'(lat), 5); chk("wr_data", q, 32'h0);
    req(1, 16'h0400, 32'h0, lat, q);
    chk("rd_after_wr", q, 32'h12345678); chk("rd_after_wr_lat", 32'(lat), 2);
    req(0, 16'h0800, 32'hCAFEF00D, lat, q);
    chk("wr_miss_lat", 32'(lat), 5);
    req(1, 16'h0400, 32'h0, lat, q);
    chk("no_alloc_lat", 32'(lat), 2); chk("no_alloc_data", q, 32'h12345678);
    req(1, 16'h0000, 32'h0, lat, q);
    chk("alias_lat", 32'(lat), 5); chk("alias_data", q, 32'hA5A50000);
    req(1, 16'h0400, 32'h0, lat, q);
    chk("evicted_lat", 32'(lat), 5); chk("wt_data", q, 32'h12345678);
    req(1, 16'h0800, 32'h0, lat, q);
    chk("wt_miss_data", q, 32'hCAFEF00D);
    cur = 0;
    rdy_cyc = -1;
    PStrobe = 1; PRW = 1; PAddress = 16'h0123; PDataIn = 32'h55;
    cyc(idle_v());
    PStrobe = 0;
    cyc(idle_v());
    e = idle_v(); e.sstb = 1; e.saddr = 16'h0123; e.sdo = 32'h55;
    PStrobe = 1; PRW = 0; PAddress = 16'h0400; PDataIn = 32'h77;
    cyc(e);
    PStrobe = 0; Reset = 1;
    cyc(idle_v());
    Reset = 0;
    clear_model();
    e = idle_v(); e.all = 1;
    cyc(e);
    for (int i = 0; i < 3; i++) cyc(idle_v());
    chk("abort_no_ready", 32'(rdy_cyc), 32'hFFFFFFFF);
    req(1, 16'h0123, 32'h0, lat, q);
    chk("post_reset_lat", 32'(lat), 5); chk("post_reset_data", q, 32'hA5A50123);
    req(1, 16'h0400, 32'h0, lat, q);
    chk("post_reset_clear_lat", 32'(lat), 5);
    for (int i = 0; i < 40; i++) req(1'($urandom_range(0, 1)), aset[$urandom_range(0, 7)], $urandom, lat, q);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
